// File: rtl/fetch_mem_unit.sv
// Memory front end for the multi-cycle RISC-V core: owns PC/OldPC/IR/Data and the shared req/ready port.
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_CHECK_EN (adds o_Misaligned).
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 15,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_PCWrite,
    input  logic        i_IRWrite,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_AdrSrc,
    input  logic [31:0] i_Result,
    input  logic [31:0] i_WriteData,
    output logic        o_MemReq,
    output logic        o_MemWe,
    output logic [31:0] o_MemAddr,
    output logic [31:0] o_MemWData,
    input  logic        i_MemRdy,
    input  logic [31:0] i_MemRData,
    output logic        o_Stall,
    output logic        o_BusError,
    output logic [31:0] o_PC,
    output logic [31:0] o_OldPC,
    output logic [31:0] o_Instr,
    output logic [31:0] o_Data,
    output logic [6:0]  o_OpCode,
    output logic [2:0]  o_funct3,
    output logic        o_funct7_5
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        o_Misaligned
`endif
);

    // state   | meaning
    // IDLE    | no access in flight; a new access is latched here
    // REQ     | o_MemReq held with latched kind/address/data until i_MemRdy
    // ERR     | wait-state timeout; stall and bus error held until reset

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        KIND_FETCH,
        KIND_READ,
        KIND_WRITE
    } kind_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state, state_nxt;
    kind_t       kind, kind_nxt, req_kind;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic [31:0] mem_addr, mem_addr_nxt;
    logic [31:0] mem_wdata, mem_wdata_nxt;
    logic [31:0] pc, old_pc, ir, data_reg;
    logic [31:0] sel_addr;
    logic        access;
    logic        misalign_hit;
    logic        misaligned;
    logic        stall;
    logic        fetch_done;
    logic        read_done;

    assign access   = i_IRWrite | i_MemRead | i_MemWrite;
    assign sel_addr = i_AdrSrc ? i_Result : pc;

    always_comb begin
        req_kind = KIND_WRITE;
        if (i_IRWrite)
            req_kind = KIND_FETCH;
        else if (i_MemRead)
            req_kind = KIND_READ;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_hit = i_IRWrite && (sel_addr[1:0] != 2'b00);
`else
    assign misalign_hit = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        kind_nxt      = kind;
        wait_cnt_nxt  = wait_cnt;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        stall         = 1'b0;
        misaligned    = 1'b0;
        fetch_done    = 1'b0;
        read_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (misalign_hit) begin
                        misaligned = 1'b1;
                    end else begin
                        stall         = 1'b1;
                        state_nxt     = ST_REQ;
                        wait_cnt_nxt  = 8'd0;
                        kind_nxt      = req_kind;
                        mem_addr_nxt  = sel_addr;
                        mem_wdata_nxt = i_WriteData;
                    end
                end
            end
            ST_REQ: begin
                if (i_MemRdy) begin
                    state_nxt  = ST_IDLE;
                    fetch_done = (kind == KIND_FETCH);
                    read_done  = (kind == KIND_READ);
                end else begin
                    stall = 1'b1;
                    // counter value equals the number of unanswered REQ cycles before this one
                    if (wait_cnt == MAX_WAIT_C)
                        state_nxt = ST_ERR;
                    else
                        wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ST_ERR: begin
                stall = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state     <= ST_IDLE;
            kind      <= KIND_FETCH;
            wait_cnt  <= 8'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            pc        <= RESET_PC;
            old_pc    <= RESET_PC;
            ir        <= NOP_INSTR;
            data_reg  <= 32'd0;
        end else begin
            state     <= state_nxt;
            kind      <= kind_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if (i_PCWrite && !stall)
                pc <= i_Result;
            if (fetch_done) begin
                ir     <= i_MemRData;
                old_pc <= mem_addr;
            end
            if (read_done)
                data_reg <= i_MemRData;
        end
    end

    assign o_MemReq   = (state == ST_REQ);
    assign o_MemWe    = (state == ST_REQ) && (kind == KIND_WRITE);
    assign o_MemAddr  = mem_addr;
    assign o_MemWData = mem_wdata;
    assign o_Stall    = stall;
    assign o_BusError = (state == ST_ERR);
    assign o_PC       = pc;
    assign o_OldPC    = old_pc;
    assign o_Instr    = ir;
    assign o_Data     = data_reg;
    assign o_OpCode   = ir[6:0];
    assign o_funct3   = ir[14:12];
    assign o_funct7_5 = ir[30];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign o_Misaligned = misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed self-checking bench for fetch_mem_unit: fetch, data read/write, PC update, timeout, reset.
module tb_fetch_mem_unit;

    logic        i_Clk = 1'b0;
    logic        i_Reset, i_PCWrite, i_IRWrite, i_MemRead, i_MemWrite, i_AdrSrc;
    logic [31:0] i_Result, i_WriteData, i_MemRData;
    logic        i_MemRdy;
    logic        o_MemReq, o_MemWe, o_Stall, o_BusError, o_funct7_5;
    logic [31:0] o_MemAddr, o_MemWData, o_PC, o_OldPC, o_Instr, o_Data;
    logic [6:0]  o_OpCode;
    logic [2:0]  o_funct3;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        o_Misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cycles;

    always #5 i_Clk = ~i_Clk;

    fetch_mem_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_PCWrite  (i_PCWrite),
        .i_IRWrite  (i_IRWrite),
        .i_MemRead  (i_MemRead),
        .i_MemWrite (i_MemWrite),
        .i_AdrSrc   (i_AdrSrc),
        .i_Result   (i_Result),
        .i_WriteData(i_WriteData),
        .o_MemReq   (o_MemReq),
        .o_MemWe    (o_MemWe),
        .o_MemAddr  (o_MemAddr),
        .o_MemWData (o_MemWData),
        .i_MemRdy   (i_MemRdy),
        .i_MemRData (i_MemRData),
        .o_Stall    (o_Stall),
        .o_BusError (o_BusError),
        .o_PC       (o_PC),
        .o_OldPC    (o_OldPC),
        .o_Instr    (o_Instr),
        .o_Data     (o_Data),
        .o_OpCode   (o_OpCode),
        .o_funct3   (o_funct3),
        .o_funct7_5 (o_funct7_5)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .o_Misaligned(o_Misaligned)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    // Caller sets the request inputs right after a step(); this runs IDLE + n_wait stalled REQ cycles + ready cycle.
    task automatic do_access(input int n_wait, input logic [31:0] exp_addr, input logic exp_we,
                             input logic [31:0] exp_wdata, input logic [31:0] rdata,
                             input logic [31:0] res_on_ready, input logic [31:0] exp_pc,
                             input logic [31:0] exp_ir_prev, output int stalls);
        stalls = 0;
        #1;
        check("idle_req", 32'(o_MemReq), 32'd0);
        if (o_Stall) stalls++;
        step();
        i_IRWrite  = 1'b0;
        i_MemRead  = 1'b0;
        i_MemWrite = 1'b0;
        for (int w = 0; w < n_wait; w++) begin
            i_MemRdy    = 1'b0;
            i_Result    = i_Result ^ 32'hFFFF_FFF0;
            i_WriteData = ~i_WriteData;
            #1;
            if (o_Stall) stalls++;
            check("wait_req", 32'(o_MemReq), 32'd1);
            check("wait_addr", o_MemAddr, exp_addr);
            check("wait_we", 32'(o_MemWe), 32'(exp_we));
            if (exp_we) check("wait_wdata", o_MemWData, exp_wdata);
            check("wait_pc", o_PC, exp_pc);
            check("wait_ir", o_Instr, exp_ir_prev);
            step();
        end
        i_MemRdy   = 1'b1;
        i_MemRData = rdata;
        i_Result   = res_on_ready;
        #1;
        if (o_Stall) stalls++;
        check("rdy_req", 32'(o_MemReq), 32'd1);
        check("rdy_addr", o_MemAddr, exp_addr);
        check("rdy_we", 32'(o_MemWe), 32'(exp_we));
        if (exp_we) check("rdy_wdata", o_MemWData, exp_wdata);
        step();
        i_MemRdy   = 1'b0;
        i_MemRData = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 1'b1; i_PCWrite = 1'b0; i_IRWrite = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
        i_AdrSrc = 1'b0; i_Result = 32'd0; i_WriteData = 32'd0; i_MemRdy = 1'b0; i_MemRData = 32'd0;
        step();
        step();
        i_Reset = 1'b0;
        #1;
        check("rst_pc", o_PC, 32'd0);
        check("rst_oldpc", o_OldPC, 32'd0);
        check("rst_ir", o_Instr, 32'h0000_0013);
        check("rst_data", o_Data, 32'd0);
        check("rst_req", 32'(o_MemReq), 32'd0);
        check("rst_stall", 32'(o_Stall), 32'd0);
        check("rst_berr", 32'(o_BusError), 32'd0);
        step();

        // plain fetch, ready on first REQ cycle
        i_IRWrite = 1'b1; i_AdrSrc = 1'b0;
        do_access(0, 32'd0, 1'b0, 32'd0, 32'h0050_0093, 32'd0, 32'd0, 32'h0000_0013, stall_cycles);
        check("f1_stalls", 32'(stall_cycles), 32'd1);
        check("f1_ir", o_Instr, 32'h0050_0093);
        check("f1_opcode", 32'(o_OpCode), 32'h13);
        check("f1_funct3", 32'(o_funct3), 32'd0);
        check("f1_oldpc", o_OldPC, 32'd0);
        check("f1_req_after", 32'(o_MemReq), 32'd0);

        // PC write held during stall, lands together with fetch completion
        i_IRWrite = 1'b1; i_AdrSrc = 1'b0; i_PCWrite = 1'b1; i_Result = 32'd4;
        do_access(2, 32'd0, 1'b0, 32'd0, 32'h4000_0033, 32'd4, 32'd0, 32'h0050_0093, stall_cycles);
        check("pc_stalls", 32'(stall_cycles), 32'd3);
        check("pc_after", o_PC, 32'd4);
        check("pc_oldpc", o_OldPC, 32'd0);
        check("pc_ir", o_Instr, 32'h4000_0033);
        check("pc_opcode", 32'(o_OpCode), 32'h33);
        check("pc_f7", 32'(o_funct7_5), 32'd1);
        i_Result = 32'd8;
        #1;
        check("pc2_stall", 32'(o_Stall), 32'd0);
        step();
        i_PCWrite = 1'b0;
        check("pc2_after", o_PC, 32'd8);

        // fetch with 3 wait states, i_Result toggling
        i_IRWrite = 1'b1; i_AdrSrc = 1'b0; i_Result = 32'h0000_1234;
        do_access(3, 32'd8, 1'b0, 32'd0, 32'h0020_C133, 32'd8, 32'd8, 32'h4000_0033, stall_cycles);
        check("f3_stalls", 32'(stall_cycles), 32'd4);
        check("f3_ir", o_Instr, 32'h0020_C133);
        check("f3_funct3", 32'(o_funct3), 32'd4);
        check("f3_oldpc", o_OldPC, 32'd8);
        check("f3_pc", o_PC, 32'd8);

        // data read via i_Result
        i_MemRead = 1'b1; i_AdrSrc = 1'b1; i_Result = 32'h200;
        do_access(1, 32'h200, 1'b0, 32'd0, 32'hCAFE_F00D, 32'h200, 32'd8, 32'h0020_C133, stall_cycles);
        check("rd_data", o_Data, 32'hCAFE_F00D);
        check("rd_ir", o_Instr, 32'h0020_C133);
        check("rd_oldpc", o_OldPC, 32'd8);

        // all three requests: fetch wins
        i_IRWrite = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b1; i_AdrSrc = 1'b0; i_Result = 32'h300;
        do_access(0, 32'd8, 1'b0, 32'd0, 32'h00A0_0113, 32'h300, 32'd8, 32'h0020_C133, stall_cycles);
        check("pri_ir", o_Instr, 32'h00A0_0113);
        check("pri_data", o_Data, 32'hCAFE_F00D);

        // data write, write data stable while inputs change
        i_MemWrite = 1'b1; i_AdrSrc = 1'b1; i_Result = 32'h100; i_WriteData = 32'hDEAD_BEEF;
        do_access(2, 32'h100, 1'b1, 32'hDEAD_BEEF, 32'h5555_5555, 32'h100, 32'd8, 32'h00A0_0113, stall_cycles);
        check("wr_stalls", 32'(stall_cycles), 32'd3);
        check("wr_data", o_Data, 32'hCAFE_F00D);
        check("wr_ir", o_Instr, 32'h00A0_0113);
        check("wr_we_after", 32'(o_MemWe), 32'd0);

        // memory never ready: 16 REQ cycles then bus error
        i_IRWrite = 1'b1; i_AdrSrc = 1'b0;
        #1;
        check("to_stall0", 32'(o_Stall), 32'd1);
        step();
        i_IRWrite = 1'b0;
        for (int r = 0; r < 16; r++) begin
            check("to_req", 32'(o_MemReq), 32'd1);
            check("to_berr_pre", 32'(o_BusError), 32'd0);
            step();
        end
        check("to_berr", 32'(o_BusError), 32'd1);
        check("to_req_off", 32'(o_MemReq), 32'd0);
        check("to_stall", 32'(o_Stall), 32'd1);
        i_PCWrite = 1'b1; i_Result = 32'h40;
        step();
        i_PCWrite = 1'b0;
        check("to_sticky", 32'(o_BusError), 32'd1);
        check("to_pc_frozen", o_PC, 32'd8);
        i_Reset = 1'b1;
        step();
        i_Reset = 1'b0;
        #1;
        check("clr_berr", 32'(o_BusError), 32'd0);
        check("clr_stall", 32'(o_Stall), 32'd0);
        check("clr_req", 32'(o_MemReq), 32'd0);
        check("clr_pc", o_PC, 32'd0);
        check("clr_ir", o_Instr, 32'h0000_0013);
        check("clr_data", o_Data, 32'd0);
        step();

        // reset while a fetch is in flight
        i_IRWrite = 1'b1; i_AdrSrc = 1'b0;
        step();
        i_IRWrite = 1'b0; i_Reset = 1'b1; i_MemRdy = 1'b1; i_MemRData = 32'h1111_1111;
        #1;
        check("rr_req", 32'(o_MemReq), 32'd1);
        step();
        i_Reset = 1'b0; i_MemRdy = 1'b0; i_MemRData = 32'd0;
        #1;
        check("rr_req_off", 32'(o_MemReq), 32'd0);
        check("rr_ir", o_Instr, 32'h0000_0013);
        step();

`ifdef FETCH_MISALIGN_CHECK_EN
        i_PCWrite = 1'b1; i_Result = 32'h2;
        step();
        i_PCWrite = 1'b0; i_IRWrite = 1'b1; i_AdrSrc = 1'b0;
        #1;
        check("mis_pc", o_PC, 32'h2);
        check("mis_flag", 32'(o_Misaligned), 32'd1);
        check("mis_stall", 32'(o_Stall), 32'd0);
        step();
        i_IRWrite = 1'b0;
        #1;
        check("mis_flag_off", 32'(o_Misaligned), 32'd0);
        check("mis_req", 32'(o_MemReq), 32'd0);
        check("mis_ir", o_Instr, 32'h0000_0013);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
